// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel strobe, raster position and decoded sync/blank flags.
interface vga_timing_gen_if;
  logic       p_tick;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input  p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: divides clk into a pixel strobe and scans h/v counters,
// emitting glitch-free registered sync, blanking and end-of-frame flags.
module vga_timing_gen #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned DIV       = 4
) (
  input  logic             clk,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned CW       = 10;
  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_DISPLAY + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_DISPLAY + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] div_cnt, div_nxt;
  logic [CW-1:0] h_cnt, h_nxt;
  logic [CW-1:0] v_cnt, v_nxt;
  logic          h_wrap;
  logic          p_tick, p_tick_nxt;
  logic          frame_tick, frame_nxt;
  logic          video_on, video_nxt;
  logic          hsync, hsync_nxt;
  logic          vsync, vsync_nxt;

  // Next-state counters; flags decode the next values so they land with the counters.
  always_comb begin
    div_nxt    = (div_cnt >= DW'(DIV - 1)) ? '0 : div_cnt + DW'(1);
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    h_wrap     = (h_cnt >= CW'(H_TOTAL - 1));
    if (p_tick) begin
      h_nxt = h_wrap ? '0 : h_cnt + CW'(1);
      // Out-of-range rows are flushed even off a line wrap.
      if (h_wrap || (v_cnt > CW'(V_TOTAL - 1))) begin
        v_nxt = (v_cnt >= CW'(V_TOTAL - 1)) ? '0 : v_cnt + CW'(1);
      end
    end
    p_tick_nxt = (div_nxt == DW'(DIV - 1));
    frame_nxt  = p_tick && (h_cnt == CW'(H_TOTAL - 1)) && (v_cnt == CW'(V_TOTAL - 1));
    video_nxt  = (h_nxt < CW'(H_DISPLAY)) && (v_nxt < CW'(V_DISPLAY));
    hsync_nxt  = !((h_nxt >= CW'(HS_START)) && (h_nxt < CW'(HS_END)));
    vsync_nxt  = !((v_nxt >= CW'(VS_START)) && (v_nxt < CW'(VS_END)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      p_tick     <= 1'b0;
      frame_tick <= 1'b0;
      video_on   <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
    end else begin
      div_cnt    <= div_nxt;
      h_cnt      <= h_nxt;
      v_cnt      <= v_nxt;
      p_tick     <= p_tick_nxt;
      frame_tick <= frame_nxt;
      video_on   <= video_nxt;
      hsync      <= hsync_nxt;
      vsync      <= vsync_nxt;
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.pixel_x    = h_cnt;
  assign vga.pixel_y    = v_cnt;
  assign vga.video_on   = video_on;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a shrunken raster and the 640x480 default run side by
// side against a closed-form model of position versus clocks since reset release.
module tb_vga_timing_gen;

  localparam int unsigned DIV = 4;
  localparam int unsigned S_HD = 16, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int unsigned S_VD = 8,  S_VF = 2, S_VS = 2, S_VB = 3;

  typedef struct packed {
    logic       pt;
    logic [9:0] px;
    logic [9:0] py;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;

  typedef struct {
    int unsigned hd, hf, hs, hb, vd, vf, vs, vb;
  } cfg_t;

  logic clk = 1'b0;
  logic reset;

  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_d ();

  vga_timing_gen #(
    .H_DISPLAY(S_HD), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_DISPLAY(S_VD), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .DIV(DIV)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .vga   (if_s)
  );

  vga_timing_gen dut_d (
    .clk   (clk),
    .reset (reset),
    .vga   (if_d)
  );

  always #5 clk = ~clk;

  obs_t obs_s, obs_d;
  assign obs_s = {if_s.p_tick, if_s.pixel_x, if_s.pixel_y, if_s.video_on,
                  if_s.hsync, if_s.vsync, if_s.frame_tick};
  assign obs_d = {if_d.p_tick, if_d.pixel_x, if_d.pixel_y, if_d.video_on,
                  if_d.hsync, if_d.vsync, if_d.frame_tick};

  cfg_t        cfg [2];
  int unsigned k;
  longint      cyc;
  int          n_assert = 0;
  int          n_fail   = 0;
  longint      last_pt [2];
  longint      last_ft [2];
  int          hs_run  [2];
  int          vs_run  [2];

  function automatic int unsigned h_total(input cfg_t c);
    return c.hd + c.hf + c.hs + c.hb;
  endfunction

  function automatic int unsigned v_total(input cfg_t c);
    return c.vd + c.vf + c.vs + c.vb;
  endfunction

  // kk = clk edges since reset release; one pixel step per DIV edges.
  function automatic obs_t model(input int unsigned kk, input cfg_t c);
    int unsigned ht, vt, t, x, y;
    obs_t m;
    ht = h_total(c);
    vt = v_total(c);
    t  = kk / DIV;
    x  = t % ht;
    y  = (t / ht) % vt;
    m.pt  = (kk > 0) && (kk % DIV == DIV - 1);
    m.px  = 10'(x);
    m.py  = 10'(y);
    m.von = (kk > 0) && (x < c.hd) && (y < c.vd);
    m.hs  = !((x >= c.hd + c.hf) && (x < c.hd + c.hf + c.hs));
    m.vs  = !((y >= c.vd + c.vf) && (y < c.vd + c.vf + c.vs));
    m.ft  = (kk > 0) && (kk % DIV == 0) && (t % (ht * vt) == 0);
    return m;
  endfunction

  task automatic clear_trackers();
    for (int i = 0; i < 2; i++) begin
      last_pt[i] = -1;
      last_ft[i] = -1;
      hs_run[i]  = 0;
      vs_run[i]  = 0;
    end
  endtask

  task automatic check(input int i, input obs_t got, input string tag);
    obs_t        exp;
    int unsigned ht, vt;
    exp = model(k, cfg[i]);
    ht  = h_total(cfg[i]);
    vt  = v_total(cfg[i]);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, got, exp);
    end
    if (got.pt === 1'b1) begin
      if (last_pt[i] >= 0) begin
        n_assert++;
        assert (cyc - last_pt[i] == longint'(DIV)) else begin
          n_fail++;
          $error("FAIL %s_ptick_gap observed=%0d expected=%0d", tag, cyc - last_pt[i], DIV);
        end
      end
      last_pt[i] = cyc;
    end
    if (got.ft === 1'b1) begin
      if (last_ft[i] >= 0) begin
        n_assert++;
        assert (cyc - last_ft[i] == longint'(DIV * ht * vt)) else begin
          n_fail++;
          $error("FAIL %s_frame_spacing observed=%0d expected=%0d", tag, cyc - last_ft[i], DIV * ht * vt);
        end
      end
      last_ft[i] = cyc;
    end
    if (got.hs === 1'b0) hs_run[i]++;
    else if (hs_run[i] > 0) begin
      n_assert++;
      assert (hs_run[i] == int'(cfg[i].hs * DIV)) else begin
        n_fail++;
        $error("FAIL %s_hsync_width observed=%0d expected=%0d", tag, hs_run[i], cfg[i].hs * DIV);
      end
      hs_run[i] = 0;
    end
    if (got.vs === 1'b0) vs_run[i]++;
    else if (vs_run[i] > 0) begin
      n_assert++;
      assert (vs_run[i] == int'(cfg[i].vs * ht * DIV)) else begin
        n_fail++;
        $error("FAIL %s_vsync_width observed=%0d expected=%0d", tag, vs_run[i], cfg[i].vs * ht * DIV);
      end
      vs_run[i] = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) k++;
    @(negedge clk);
    check(0, obs_s, "small");
    check(1, obs_d, "vga640");
  endtask

  // Reset lands between edges and must take effect before any further clk edge.
  task automatic async_reset(input int unsigned hold);
    #($urandom_range(1, 3));
    reset = 1'b1;
    k     = 0;
    clear_trackers();
    #1;
    check(0, obs_s, "small_async");
    check(1, obs_d, "vga640_async");
    repeat (hold) step();
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    cfg[0] = '{S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB};
    cfg[1] = '{640, 16, 96, 48, 480, 10, 2, 33};
    reset  = 1'b1;
    k      = 0;
    cyc    = 0;
    clear_trackers();

    repeat (3) step();
    reset = 1'b0;

    // Two full default lines, several small frames.
    repeat (2 * 3200 + $urandom_range(0, 400)) step();

    // Park the small raster inside its hsync pulse, then hit reset.
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      step();
      if (obs_s.px == 10'(S_HD + S_HF + 1) && obs_s.py >= 10'd4) found = 1'b1;
    end
    n_assert++;
    assert (found === 1'b1) else begin
      n_fail++;
      $error("FAIL wait_hsync_window observed=%0d expected=1", found);
    end
    async_reset($urandom_range(1, 6));
    repeat (2000) step();

    for (int r = 0; r < 5; r++) begin
      repeat ($urandom_range(50, 2500)) step();
      async_reset($urandom_range(1, 4));
    end
    repeat (1600) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
